// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit seven-segment
//            display. Holds a 16-bit hex value with per-digit decimal points,
//            walks the digits at PRESCALE cycles per slot, and commits newly
//            loaded values only on frame boundaries so a frame never tears.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   enable_i     in   1 = scanning, 0 = dark and held at digit 0
//   load_i       in   load request, accepted when load_i && ready_o
//   value_i      in   [15:12] digit 3 (leftmost) ... [3:0] digit 0
//   dp_i         in   decimal point per digit, 1 = lit
//   lz_en_i      in   leading-zero suppression enable (sampled live)
//   ready_o      out  1 when no load is waiting to be committed
//   an_o         out  digit anodes, active low, at most one low
//   hex_o        out  nibble for the shared seven-segment decoder
//   dp_n_o       out  decimal point, active low
//   frame_done_o out  one-cycle pulse, first cycle of digit 0 in a new frame
// ============================================================================
module seg_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        lz_en_i,
  output logic        ready_o,
  output logic [3:0]  an_o,
  output logic [3:0]  hex_o,
  output logic        dp_n_o,
  output logic        frame_done_o
);

  localparam int unsigned      CNT_W   = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  // Display and shadow registers
  logic [15:0] disp_q, disp_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;

  // A frame-boundary commit is flagged for one cycle so that pending clears
  // (ready rises) exactly when digit 0 of the new frame reaches the outputs.
  logic        commit_q, commit_d;
  logic        wrap_q, wrap_d;

  // Registered outputs
  logic [3:0]  an_q, an_d;
  logic [3:0]  hex_q, hex_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_done_q, frame_done_d;

  logic        tick;
  logic        wrap;
  logic        accept;
  logic [3:0]  blank;

  assign tick   = (cnt_q == CNT_MAX);
  assign wrap   = tick && (idx_q == 2'd3);
  assign accept = load_i && !pending_q;

  // Digit i (i > 0) is blank when it and every digit to its left are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = lz_en_i && (disp_q[15:12] == 4'h0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'h0);
    blank[1] = blank[2] && (disp_q[7:4]  == 4'h0);
  end

  // Scan, handshake and commit
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    commit_d    = 1'b0;
    wrap_d      = 1'b0;

    if (!enable_i) begin
      cnt_d = '0;
      idx_d = 2'd0;
      if (pending_q) begin
        // Nothing is on screen, so pending data can land at once.
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d  = tick ? idx_q + 2'd1 : idx_q;
      wrap_d = wrap;
      if (wrap && pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
        commit_d  = 1'b1;
      end
      if (commit_q) begin
        pending_d = 1'b0;
      end
    end

    // accept requires pending_q == 0, so it never collides with a commit.
    if (accept) begin
      shadow_d    = value_i;
      shadow_dp_d = dp_i;
      pending_d   = 1'b1;
    end
  end

  // Output decode from the current (post-edge) scan state, one cycle behind.
  always_comb begin
    an_d         = 4'b1111;
    dp_n_d       = 1'b1;
    hex_d        = disp_q[{idx_q, 2'b00} +: 4];
    frame_done_d = enable_i && wrap_q;
    if (enable_i && !blank[idx_q]) begin
      an_d   = ~(4'b0001 << idx_q);
      dp_n_d = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      disp_dp_q    <= 4'h0;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      pending_q    <= 1'b0;
      commit_q     <= 1'b0;
      wrap_q       <= 1'b0;
      an_q         <= 4'b1111;
      hex_q        <= 4'h0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      commit_q     <= commit_d;
      wrap_q       <= wrap_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready_o      = ~pending_q;
  assign an_o         = an_q;
  assign hex_o        = hex_q;
  assign dp_n_o       = dp_n_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. Holds a 16-bit display value with per-digit decimal points and walks the digits at a programmable refresh rate. Presents one hex nibble at a time to the shared `SevenSegment` decoder and drives active-low digit anodes and the decimal point. Accepts new values through a valid/ready load handshake and commits them only at frame boundaries, so a digit never tears mid-frame.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; legal range is 2 to 2^20.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: 1 = scanning; 0 = display dark and scan held at digit 0.
- `load` input, 1 bit: request to load `value`/`dp_in`; accepted when `load && ready`.
- `value` input, 16 bits: four hex nibbles; [15:12] is digit 3 (leftmost), [3:0] is digit 0.
- `dp_in` input, 4 bits: decimal point per digit, 1 = lit; bit i belongs to digit i.
- `lz_en` input, 1 bit: leading-zero suppression enable; sampled live.
- `ready` output, 1 bit: 1 when no load is pending commit.
- `an` output, 4 bits: digit anodes, active low; at most one bit is 0.
- `hex` output, 4 bits: nibble for the `SevenSegment` decoder.
- `dp_n` output, 1 bit: decimal point, active low.
- `frame_done` output, 1 bit: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- State: prescale counter `cnt` (0..PRESCALE-1), digit index `idx` (0..3), display registers `disp[15:0]`/`disp_dp[3:0]`, shadow registers, and a `pending` flag.
- Prescaler: while `enable`=1, `cnt` increments every cycle. At PRESCALE-1 it wraps to 0 and asserts the internal `tick` for that cycle.
- On `tick`, `idx` advances to `idx+1` mod 4.
- When `tick` occurs with `idx`=3:
  - `idx` becomes 0.
  - `frame_done` pulses.
  - If `pending`=1, `disp`/`disp_dp` take the shadow values and `pending` clears.
- Load handshake: `ready` = ~`pending`.
  - When `load && ready`, the shadow registers capture `value`/`dp_in` and `pending` sets.
  - When `load` is asserted with `ready`=0, it is ignored; the shadow registers are unchanged and no queueing occurs.
- Load in the same cycle as a commit: the commit uses the old shadow contents. Because `ready` was 0 that cycle, the new load is not accepted.
- `enable`=0:
  - `cnt` and `idx` are forced to 0 and `frame_done` is 0.
  - Any pending shadow data is committed immediately and `pending` clears.
  - Loads while disabled commit on the next cycle; `ready` drops for exactly one cycle.
- Leading-zero suppression, when `lz_en`=1: digit i (i = 3, 2, 1) is blanked if every nibble of `disp` from digit 3 down to digit i is 0. Digit 0 is never blanked.
- A blanked digit drives `an`=4'b1111 for its slot and `dp_n`=1; the slot length is unchanged.
- Output decode, registered from the post-edge `idx`/`disp`:
  - `an` = ~(1<<idx), or 4'b1111 if the digit is blanked or `enable`=0.
  - `hex` = `disp[4*idx +: 4]`.
  - `dp_n` = ~`disp_dp[idx]`, or 1 if blanked or disabled.
- Reset values: `cnt`=0, `idx`=0, `disp`=0, `disp_dp`=0, shadow=0, `pending`=0, `an`=4'b1111, `hex`=0, `dp_n`=1, `ready`=1, `frame_done`=0.
- The first valid `an` appears one cycle after `rst_n` deasserts with `enable`=1.

## Timing
- Every output is a flop; there are no combinational input-to-output paths.
- Output latency: `an`/`hex`/`dp_n` change one cycle after the edge on which `idx` changes.
- Each digit is displayed for exactly PRESCALE cycles; a frame is 4*PRESCALE cycles.
- `frame_done` is high in the cycle after the wrap edge, aligned with the first cycle in which digit 0 is shown with committed data.
- Load-to-display latency, `enable`=1: 1 to 4*PRESCALE cycles after acceptance, landing on the next frame boundary.
- `ready` returns to 1 in the same cycle `frame_done` is 1.
- `rst_n` assertion mid-frame: all state returns to reset values immediately (asynchronous). Any pending load is discarded.
- `enable` falling mid-slot: `an`=4'b1111 on the next cycle.
- `enable` rising: digit 0 is displayed for a full PRESCALE slot, starting one cycle later.

## Test plan
- Reset and basic scan, PRESCALE=4, `enable`=1:
  - Stimulus: load 16'h1234, `dp_in`=4'b0000.
  - Required: `an` cycles 1110, 1101, 1011, 0111, 4 cycles each; `hex` = 4, 3, 2, 1 respectively; `dp_n`=1 throughout.
  - Required: `frame_done` pulses every 16 cycles.
- Frame-boundary commit:
  - Stimulus: load 16'hABCD mid-slot of digit 1.
  - Required: `ready`=0 until wrap; digits 2 and 3 still show the old value; the first 4'hD on digit 0 coincides with `frame_done`=1 and `ready`=1.
- Back-pressure:
  - Stimulus: a second `load` with 16'hFFFF while pending.
  - Required: ignored; the display commits the first value only; a subsequent `load` after `ready`=1 is accepted.
- Leading-zero suppression:
  - Stimulus: `disp`=16'h0050, `lz_en`=1.
  - Required: `an`=1111 during the digit 3 and digit 2 slots; digits 1 and 0 show 5 and 0.
  - Stimulus: `disp`=16'h0000.
  - Required: only digit 0 lit, `hex`=0.
- Decimal point and disable:
  - Stimulus: `dp_in`=4'b0100.
  - Required: `dp_n`=0 only in the digit 2 slot.
  - Stimulus: drop `enable` mid-slot.
  - Required: `an`=1111 and `dp_n`=1 next cycle; pending data commits within 1 cycle; re-enable restarts at digit 0.
- Asynchronous reset mid-operation:
  - Stimulus: assert `rst_n`=0 between clock edges with a load pending.
  - Required: immediately `an`=1111, `ready`=1, `hex`=0; after release the display shows 0000 and the pending value is lost.
